// File: rtl/player_control_if.sv
// -----------------------------------------------------------------------------
// player_control_if
// Bundles the player_control I/O apart from clk/rst.
//   KEY[3:0]    raw push-buttons, active-low, asynchronous (0 right, 1 left,
//               2 recentre, 3 unused)
//   vsync       VGA vertical sync, active-low pulse
//   player_x    box left-edge X coordinate
//   dir         motion state: 00 idle, 01 right, 10 left
//   frame_tick  one-cycle pulse per vsync assertion
// master: the side that drives keys/vsync and consumes position.
// slave : player_control itself.
// -----------------------------------------------------------------------------
interface player_control_if;
    logic [3:0] KEY;
    logic       vsync;
    logic [9:0] player_x;
    logic [1:0] dir;
    logic       frame_tick;

    modport master (
        output KEY,
        output vsync,
        input  player_x,
        input  dir,
        input  frame_tick
    );

    modport slave (
        input  KEY,
        input  vsync,
        output player_x,
        output dir,
        output frame_tick
    );
endinterface

// File: rtl/player_control.sv
// -----------------------------------------------------------------------------
// player_control
// Turns the push-buttons into the horizontal box position for the renderer.
// Keys and vsync are synchronised, keys are debounced, and the position moves
// at most once per frame (on frame_tick) so the box never tears mid-scan.
// The box is clamped to stay fully inside the active width.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  player_control_if.slave (KEY, vsync in; player_x, dir, frame_tick out)
// -----------------------------------------------------------------------------
module player_control #(
    parameter logic [9:0] BOX_WIDTH       = 10'd30,
    parameter logic [9:0] MOVE_STEP       = 10'd4,
    parameter logic [9:0] SCREEN_WIDTH    = 10'd640,
    parameter logic [9:0] X_START         = 10'd305,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         DB_BITS         = 20
) (
    input  logic              clk,
    input  logic              rst,
    player_control_if.slave   bus
);

    localparam logic [9:0]         X_MAX   = SCREEN_WIDTH - BOX_WIDTH;
    localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10
    } dir_t;

    // Synchroniser chains; index 0 right, 1 left, 2 recentre
    logic [2:0]         key_s1_q, key_s2_q;
    logic               vs_s1_q, vs_s2_q, vs3_q;

    logic [2:0]         db_q, db_d;
    logic [DB_BITS-1:0] cnt_q [3];
    logic [DB_BITS-1:0] cnt_d [3];

    logic               recentre_pend_q, recentre_pend_d;
    logic               frame_tick_q, frame_tick_d;
    dir_t               dir_q, dir_d;
    logic [9:0]         player_x_q, player_x_d;

    logic               center_fall;
    logic [10:0]        sum_right;
    logic               key3_unused;

    assign key3_unused = bus.KEY[3];

    always_comb begin
        // Debounce: db follows the synced level only after it has differed
        // for DEBOUNCE_CYCLES consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (key_s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = key_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_BITS'(1);
                end
            end
        end

        // Tick on the first synced-low sample after a high one
        frame_tick_d = ~vs_s2_q & vs3_q;

        // Set wins over clear so a press coinciding with a tick is kept
        center_fall     = db_q[2] & ~db_d[2];
        recentre_pend_d = center_fall | (recentre_pend_q & ~frame_tick_q);

        unique case ({db_q[1], db_q[0]})
            2'b10:   dir_d = RIGHT;
            2'b01:   dir_d = LEFT;
            default: dir_d = IDLE;
        endcase

        // 11-bit sum so the clamp compare cannot wrap
        sum_right  = {1'b0, player_x_q} + {1'b0, MOVE_STEP};
        player_x_d = player_x_q;
        if (frame_tick_q) begin
            if (recentre_pend_q) begin
                player_x_d = X_START;
            end else begin
                unique case (dir_q)
                    RIGHT:   player_x_d = (sum_right > {1'b0, X_MAX}) ? X_MAX : sum_right[9:0];
                    LEFT:    player_x_d = (player_x_q < MOVE_STEP) ? '0 : player_x_q - MOVE_STEP;
                    default: player_x_d = player_x_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1_q        <= '1;
            key_s2_q        <= '1;
            vs_s1_q         <= 1'b1;
            vs_s2_q         <= 1'b1;
            vs3_q           <= 1'b1;
            db_q            <= '1;
            cnt_q           <= '{default: '0};
            recentre_pend_q <= 1'b0;
            frame_tick_q    <= 1'b0;
            dir_q           <= IDLE;
            player_x_q      <= X_START;
        end else begin
            key_s1_q        <= bus.KEY[2:0];
            key_s2_q        <= key_s1_q;
            vs_s1_q         <= bus.vsync;
            vs_s2_q         <= vs_s1_q;
            vs3_q           <= vs_s2_q;
            db_q            <= db_d;
            cnt_q           <= cnt_d;
            recentre_pend_q <= recentre_pend_d;
            frame_tick_q    <= frame_tick_d;
            dir_q           <= dir_d;
            player_x_q      <= player_x_d;
        end
    end

    assign bus.player_x   = player_x_q;
    assign bus.dir        = dir_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
